jesd204_rx_ilas_monitor: RTL

//  Per-lane ILAS (initial lane alignment sequence) monitor. Sits directly downstream of the lane CGS stage.

---
 rtl/jesd204_rx_pkg.sv | 40 ++++
 rtl/jesd204_rx_ilas_monitor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jesd204_rx_pkg.sv
// Shared JESD204 receive definitions: K-character codes and ILAS monitor state encodings.
// Used by the CGS stage, the ILAS monitor and the link config checker.
package jesd204_rx_pkg;

    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_Q = 8'h9C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_K = 8'hBC;

    // Smallest legal value of beats-per-multiframe minus 1.
    localparam logic [7:0] CFG_BEATS_MIN = 8'd3;

    localparam logic [1:0] ENC_IDLE   = 2'b00;
    localparam logic [1:0] ENC_WAIT_R = 2'b01;
    localparam logic [1:0] ENC_ILAS   = 2'b10;
    localparam logic [1:0] ENC_DONE   = 2'b11;

    // ERROR needs its own state so it does not restart, but it reports as IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_WAIT_R = 3'b001,
        ST_ILAS   = 3'b010,
        ST_DONE   = 3'b011,
        ST_ERROR  = 3'b100
    } ilas_state_e;

    function automatic logic [1:0] ilas_state_encoding(input ilas_state_e st);
        logic [1:0] enc;
        case (st)
            ST_IDLE:   enc = ENC_IDLE;
            ST_WAIT_R: enc = ENC_WAIT_R;
            ST_ILAS:   enc = ENC_ILAS;
            ST_DONE:   enc = ENC_DONE;
            ST_ERROR:  enc = ENC_IDLE;
            default:   enc = ENC_IDLE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/jesd204_rx_ilas_monitor.sv
// Per-lane ILAS monitor: checks the 4-multiframe /R/../Q/../A/ structure after CGS
// and exports the multiframe-1 config octets as four 32-bit words.
module jesd204_rx_ilas_monitor
    import jesd204_rx_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cgs_ready,
    input  logic [DATA_PATH_WIDTH*8-1:0] data,
    input  logic [DATA_PATH_WIDTH-1:0]   charisk,
    input  logic [DATA_PATH_WIDTH-1:0]   char_is_error,
    input  logic [7:0]                   cfg_beats_per_multiframe,
    output logic                         ilas_config_valid,
    output logic [1:0]                   ilas_config_addr,
    output logic [31:0]                  ilas_config_data,
    output logic                         ilas_done,
    output logic                         ilas_error,
    output logic [1:0]                   status_state
);

    ilas_state_e state_q;
    logic [1:0]  mf_cnt_q;
    logic [7:0]  beat_cnt_q;
    logic [7:0]  cfg_q;
    logic        cfg_valid_q;
    logic [1:0]  cfg_addr_q;
    logic [31:0] cfg_data_q;
    logic        done_q;
    logic        error_q;

    logic        first_s;
    logic        q_beat_s;
    logic        last_s;
    logic        cfg_beat_s;
    logic [3:0]  expect_k_s;
    logic        kcode_ok_s;
    logic        beat_ok_s;
    logic        all_k_s;
    logic        r_start_s;

    // Beat classification and per-beat structure check inside the ILAS
    always_comb begin
        first_s    = (beat_cnt_q == 8'd0) && (mf_cnt_q != 2'd0);
        q_beat_s   = (beat_cnt_q == 8'd0) && (mf_cnt_q == 2'd1);
        last_s     = (beat_cnt_q == cfg_q);
        cfg_beat_s = (mf_cnt_q == 2'd1) && (beat_cnt_q < 8'd4);
        // Exactly the octets that must carry control characters may have charisk set.
        expect_k_s = {last_s, 1'b0, q_beat_s, first_s};
        kcode_ok_s = (!first_s  || (data[7:0]   == K_R)) &&
                     (!q_beat_s || (data[15:8]  == K_Q)) &&
                     (!last_s   || (data[31:24] == K_A));
        beat_ok_s  = kcode_ok_s && (charisk == expect_k_s) && (char_is_error == 4'b0000);
        all_k_s    = (data == {4{K_K}}) && (charisk == 4'b1111);
        r_start_s  = (data[7:0] == K_R) && (charisk == 4'b0001);
    end

    // FSM, beat/multiframe counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mf_cnt_q    <= 2'd0;
            beat_cnt_q  <= 8'd0;
            cfg_q       <= 8'd0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= 2'd0;
            cfg_data_q  <= 32'h0000_0000;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            cfg_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cfg_q <= cfg_beats_per_multiframe;
                    if (cgs_ready) begin
                        state_q <= ST_WAIT_R;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_R: begin
                    if (char_is_error != 4'b0000) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end else if (all_k_s) begin
                        state_q <= ST_WAIT_R;
                    end else if (r_start_s && (cfg_q >= CFG_BEATS_MIN)) begin
                        state_q    <= ST_ILAS;
                        mf_cnt_q   <= 2'd0;
                        beat_cnt_q <= 8'd1;
                    end else begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end
                end
                ST_ILAS: begin
                    if (!beat_ok_s) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end else begin
                        if (cfg_beat_s) begin
                            cfg_valid_q <= 1'b1;
                            cfg_addr_q  <= beat_cnt_q[1:0];
                            // Word 0 carries /R/ and /Q/ in its low octets; those are not config.
                            cfg_data_q  <= (beat_cnt_q == 8'd0) ? {data[31:16], 16'h0000} : data;
                        end
                        if (last_s) begin
                            beat_cnt_q <= 8'd0;
                            if (mf_cnt_q == 2'd3) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                mf_cnt_q <= mf_cnt_q + 2'd1;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                ST_ERROR: state_q <= ST_ERROR;
                default: state_q <= ST_IDLE;
            endcase
            // Losing CGS overrides everything except the sticky error flag.
            if (!cgs_ready) begin
                state_q     <= ST_IDLE;
                done_q      <= 1'b0;
                cfg_valid_q <= 1'b0;
            end
        end
    end

    assign ilas_config_valid = cfg_valid_q;
    assign ilas_config_addr  = cfg_addr_q;
    assign ilas_config_data  = cfg_data_q;
    assign ilas_done         = done_q;
    assign ilas_error        = error_q;
    assign status_state      = ilas_state_encoding(state_q);

endmodule
